load_seq_ctrl: RTL and testbench

- Sequences one RISC-V load from issue to register writeback.
- Accepts a load request (func3, byte address, rd) from the execute stage.
- Issues a doubleword-aligned read to data memory and waits for the response.
- Selects the byte/half/word lane, sign- or zero-extends per func3, then presents the result to the register-file write port. Misaligned, illegal and timed-out loads are reported instead of written back.

---
 rtl/load_seq_if.sv | 35 +++
 rtl/load_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_load_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_seq_if.sv
// Bus bundle for load_seq_ctrl: execute-stage request, data-memory read
// channel, register-file writeback, error report and statistics.
// The slave modport is the controller's view; master is the surrounding
// pipeline/memory view.
interface load_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func3;
  logic [63:0] req_addr;
  logic [4:0]  req_rd;
  logic        mem_rd_en;
  logic [63:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [63:0] err_addr;
  logic [31:0] stat_loads;
  logic [31:0] stat_errs;

  modport slave (
    input  req_valid, req_func3, req_addr, req_rd, mem_rvalid, mem_rdata,
    output req_ready, mem_rd_en, mem_addr, wb_valid, wb_rd, wb_data,
           err_valid, err_code, err_addr, stat_loads, stat_errs
  );

  modport master (
    output req_valid, req_func3, req_addr, req_rd, mem_rvalid, mem_rdata,
    input  req_ready, mem_rd_en, mem_addr, wb_valid, wb_rd, wb_data,
           err_valid, err_code, err_addr, stat_loads, stat_errs
  );
endinterface

// File: rtl/load_seq_ctrl.sv
// load_seq_ctrl: sequences one RISC-V load from issue to writeback.
// Flow: IDLE -> REQ (read strobe) -> WAIT (bounded by TIMEOUT_CYCLES)
//       -> WB, or IDLE -> ERR for illegal/misaligned, WAIT -> ERR on timeout.
// Optional feature macro: LOAD_SEQ_STATS_EN enables saturating 32-bit
// completed-load and error counters; when undefined both read as zero.
module load_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16  // 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  load_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Last WAIT count before giving up; counter starts at zero on WAIT entry.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic [2:0]  func3_r;
  logic [63:0] addr_r;
  logic [4:0]  rd_r;
  logic        mem_rd_en_r;
  logic [63:0] mem_addr_r;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [63:0] wb_data_r;
  logic        err_valid_r;
  logic [1:0]  err_code_r;
  logic [63:0] err_addr_r;
  logic        accept_s;

  // Access size is encoded in func3[1:0]; the offset must be a multiple of it.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      2'b11:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero-extend by func3.
  function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [2:0] off,
                                              input logic [63:0] rdata);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{56{sh[7]}},  sh[7:0]};
      3'b001:  res = {{48{sh[15]}}, sh[15:0]};
      3'b010:  res = {{32{sh[31]}}, sh[31:0]};
      3'b011:  res = rdata;
      3'b100:  res = {56'd0, sh[7:0]};
      3'b101:  res = {48'd0, sh[15:0]};
      3'b110:  res = {32'd0, sh[31:0]};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  assign bus.req_ready = (state_r == IDLE) && rst_n;
  assign accept_s      = bus.req_valid && bus.req_ready;

  assign bus.mem_rd_en = mem_rd_en_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.wb_valid  = wb_valid_r;
  assign bus.wb_rd     = wb_rd_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.err_valid = err_valid_r;
  assign bus.err_code  = err_code_r;
  assign bus.err_addr  = err_addr_r;

  // Load sequencer FSM with registered strobes and held result/error fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      func3_r     <= 3'd0;
      addr_r      <= 64'd0;
      rd_r        <= 5'd0;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= 64'd0;
      wb_valid_r  <= 1'b0;
      wb_rd_r     <= 5'd0;
      wb_data_r   <= 64'd0;
      err_valid_r <= 1'b0;
      err_code_r  <= 2'd0;
      err_addr_r  <= 64'd0;
    end else begin
      mem_rd_en_r <= 1'b0;
      wb_valid_r  <= 1'b0;
      err_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            func3_r <= bus.req_func3;
            addr_r  <= bus.req_addr;
            rd_r    <= bus.req_rd;
            // Illegal func3 is reported before alignment is considered.
            if (bus.req_func3 == 3'b111) begin
              err_valid_r <= 1'b1;
              err_code_r  <= 2'b10;
              err_addr_r  <= bus.req_addr;
              state_r     <= ERR;
            end else if (is_misaligned(bus.req_func3, bus.req_addr[2:0])) begin
              err_valid_r <= 1'b1;
              err_code_r  <= 2'b01;
              err_addr_r  <= bus.req_addr;
              state_r     <= ERR;
            end else begin
              mem_rd_en_r <= 1'b1;
              mem_addr_r  <= {bus.req_addr[63:3], 3'b000};
              state_r     <= REQ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          cnt_r   <= 8'd0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            wb_valid_r <= 1'b1;
            wb_rd_r    <= rd_r;
            wb_data_r  <= load_extend(func3_r, addr_r[2:0], bus.mem_rdata);
            state_r    <= WB;
          end else if (cnt_r == TIMEOUT_LAST) begin
            err_valid_r <= 1'b1;
            err_code_r  <= 2'b11;
            err_addr_r  <= addr_r;
            state_r     <= ERR;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            state_r <= WAIT;
          end
        end
        WB:      state_r <= IDLE;
        ERR:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef LOAD_SEQ_STATS_EN
  logic [31:0] stat_loads_r;
  logic [31:0] stat_errs_r;

  // Saturating counters, bumped once per writeback / error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads_r <= 32'd0;
      stat_errs_r  <= 32'd0;
    end else begin
      if (wb_valid_r && (stat_loads_r != 32'hFFFF_FFFF)) begin
        stat_loads_r <= stat_loads_r + 32'd1;
      end else begin
        stat_loads_r <= stat_loads_r;
      end
      if (err_valid_r && (stat_errs_r != 32'hFFFF_FFFF)) begin
        stat_errs_r <= stat_errs_r + 32'd1;
      end else begin
        stat_errs_r <= stat_errs_r;
      end
    end
  end

  assign bus.stat_loads = stat_loads_r;
  assign bus.stat_errs  = stat_errs_r;
`else
  assign bus.stat_loads = 32'd0;
  assign bus.stat_errs  = 32'd0;
`endif

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Self-checking bench for load_seq_ctrl: directed cases plus randomized loads
// checked against an arithmetic reference model of the load rules.
module tb_load_seq_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  load_seq_if bus();

  load_seq_ctrl #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // observations of the most recent run_load
  bit          obs_acc;
  int          obs_rd_cnt, obs_rd_cycle, obs_wb_cycle, obs_err_cycle;
  bit          obs_both;
  logic [63:0] obs_maddr, obs_wb_data, obs_err_addr;
  logic [4:0]  obs_wb_rd;
  logic [1:0]  obs_err_code;

  // reference model outputs
  bit          exp_err;
  logic [1:0]  exp_code;
  logic [63:0] exp_data;
  int          exp_cycle, exp_rd_cnt;

  // Reference: result of a load described by its architectural rules.
  // d = cycles from the read strobe until rvalid (0 = never).
  task automatic model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rdata, input int d);
    longint unsigned size, off, v;
    size = 64'd1 << f3[1:0];
    off  = a % 8;
    v    = rdata >> (off * 8);
    exp_err = 1'b1; exp_code = 2'd0; exp_data = 64'd0; exp_rd_cnt = 0; exp_cycle = 1;
    if (f3 == 3'd7) exp_code = 2'b10;
    else if ((a % size) != 0) exp_code = 2'b01;
    else begin
      exp_rd_cnt = 1;
      if (d >= 1 && d <= T) begin
        exp_err = 1'b0; exp_cycle = d + 2;
        if (f3 == 3'd3) exp_data = rdata;
        else begin
          v = v % (64'd1 << (8 * size));
          if (f3 < 3'd3 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
          exp_data = v;
        end
      end else begin
        exp_code = 2'b11; exp_cycle = T + 2;
      end
    end
  endtask

  // Drive one request and record what the DUT does; no checking here.
  task automatic run_load(input logic [2:0] f3, input logic [63:0] a, input logic [4:0] rd,
                          input logic [63:0] rdata, input int d);
    bit done;
    obs_acc = 0; obs_rd_cnt = 0; obs_rd_cycle = -1; obs_wb_cycle = -1; obs_err_cycle = -1;
    obs_both = 0; obs_maddr = 64'd0; obs_wb_data = 64'd0; obs_err_addr = 64'd0;
    obs_wb_rd = 5'd0; obs_err_code = 2'd0;
    for (int i = 0; i < 12 && !obs_acc; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) obs_acc = 1;
    end
    if (!obs_acc) return;
    bus.req_valid = 1'b1; bus.req_func3 = f3; bus.req_addr = a; bus.req_rd = rd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_func3 = 3'($urandom);
    bus.req_addr = {$urandom, $urandom}; bus.req_rd = 5'($urandom);
    done = 0;
    for (int k = 1; k <= T + 8 && !done; k++) begin
      @(negedge clk);
      if (bus.mem_rd_en === 1'b1) begin obs_rd_cnt++; obs_rd_cycle = k; obs_maddr = bus.mem_addr; end
      if (bus.wb_valid === 1'b1 && bus.err_valid === 1'b1) obs_both = 1;
      if (bus.wb_valid === 1'b1) begin
        obs_wb_cycle = k; obs_wb_rd = bus.wb_rd; obs_wb_data = bus.wb_data; done = 1;
      end
      if (bus.err_valid === 1'b1) begin
        obs_err_cycle = k; obs_err_code = bus.err_code; obs_err_addr = bus.err_addr; done = 1;
      end
      if (!done && d > 0 && obs_rd_cycle > 0 && k == obs_rd_cycle + d) begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
      end
      if (!done) begin
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = {$urandom, $urandom};
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_rd_en, bus.wb_valid, bus.err_valid, bus.err_code, bus.wb_rd} !== 11'd0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 0", {bus.req_ready, bus.mem_rd_en, bus.wb_valid, bus.err_valid, bus.err_code, bus.wb_rd});
    end
    checks++;
    if ((bus.wb_data | bus.mem_addr | bus.err_addr) !== 64'd0 || (bus.stat_loads | bus.stat_errs) !== 32'd0) begin
      fails++; $display("FAIL reset_data got wb=%h ma=%h ea=%h exp 0", bus.wb_data, bus.mem_addr, bus.err_addr);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
  endtask

  task automatic test_directed;
    run_load(3'b000, 64'h1003, 5'd9, 64'h00000000_80FF7F00, 1);
    checks++; if (obs_maddr !== 64'h1000) begin fails++; $display("FAIL lb_mem_addr got %h exp 1000", obs_maddr); end
    checks++; if (obs_rd_cycle !== 1) begin fails++; $display("FAIL lb_rd_cycle got %0d exp 1", obs_rd_cycle); end
    checks++; if (obs_wb_cycle !== 3) begin fails++; $display("FAIL lb_wb_cycle got %0d exp 3", obs_wb_cycle); end
    checks++; if (obs_wb_data !== 64'hFFFFFFFF_FFFFFF80) begin fails++; $display("FAIL lb_data got %h exp ffffffffffffff80", obs_wb_data); end
    checks++; if (obs_wb_rd !== 5'd9) begin fails++; $display("FAIL lb_rd got %0d exp 9", obs_wb_rd); end
    @(negedge clk);
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.wb_data !== 64'hFFFFFFFF_FFFFFF80) begin
      fails++; $display("FAIL wb_hold got v=%b d=%h exp v=0 d=ffffffffffffff80", bus.wb_valid, bus.wb_data);
    end
    run_load(3'b101, 64'h2006, 5'd3, 64'h80FF7F00_12345678, 2);
    checks++; if (obs_wb_data !== 64'h80FF || obs_wb_cycle !== 4) begin fails++; $display("FAIL lhu got %h@%0d exp 80ff@4", obs_wb_data, obs_wb_cycle); end
    run_load(3'b010, 64'h2004, 5'd4, 64'h80FF7F00_12345678, 1);
    checks++; if (obs_wb_data !== 64'hFFFFFFFF_80FF7F00) begin fails++; $display("FAIL lw got %h exp ffffffff80ff7f00", obs_wb_data); end
    run_load(3'b011, 64'h2000, 5'd0, 64'h80FF7F00_12345678, 1);
    checks++; if (obs_wb_data !== 64'h80FF7F00_12345678 || obs_wb_rd !== 5'd0) begin fails++; $display("FAIL ld got %h rd %0d exp 80ff7f0012345678 rd 0", obs_wb_data, obs_wb_rd); end
  endtask

  task automatic test_errors;
    run_load(3'b010, 64'h3002, 5'd5, 64'd0, 1);
    checks++; if (obs_err_cycle !== 1 || obs_err_code !== 2'b01) begin fails++; $display("FAIL misalign got code %b@%0d exp 01@1", obs_err_code, obs_err_cycle); end
    checks++; if (obs_err_addr !== 64'h3002 || obs_rd_cnt !== 0) begin fails++; $display("FAIL misalign_addr got %h rd_cnt %0d exp 3002 0", obs_err_addr, obs_rd_cnt); end
    run_load(3'b111, 64'h5001, 5'd5, 64'd0, 1);
    checks++; if (obs_err_code !== 2'b10 || obs_err_addr !== 64'h5001 || obs_rd_cnt !== 0) begin fails++; $display("FAIL illegal got code %b addr %h rd_cnt %0d exp 10 5001 0", obs_err_code, obs_err_addr, obs_rd_cnt); end
  endtask

  task automatic test_timeout;
    bit seen;
    run_load(3'b011, 64'h7008, 5'd7, 64'd0, 0);
    checks++; if (obs_err_cycle !== T + 2 || obs_err_code !== 2'b11) begin fails++; $display("FAIL timeout got code %b@%0d exp 11@%0d", obs_err_code, obs_err_cycle, T + 2); end
    checks++; if (obs_err_addr !== 64'h7008 || obs_rd_cnt !== 1 || obs_wb_cycle !== -1) begin fails++; $display("FAIL timeout_addr got %h rd_cnt %0d exp 7008 1", obs_err_addr, obs_rd_cnt); end
    // late rvalid while idle must be ignored
    seen = 0;
    @(posedge clk); #1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1234;
    repeat (3) begin @(negedge clk); if (bus.wb_valid !== 1'b0 || bus.err_valid !== 1'b0) seen = 1; end
    bus.mem_rvalid = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.wb_valid !== 1'b0 || bus.err_valid !== 1'b0) seen = 1; end
    checks++; if (seen) begin fails++; $display("FAIL late_rvalid got strobe exp none"); end
    run_load(3'b100, 64'h8005, 5'd11, 64'hAA00_0000_0000_0000 | 64'h0000_F100_0000_0000, 1);
    checks++; if (obs_wb_data !== 64'hF1 || obs_wb_cycle !== 3 || obs_wb_rd !== 5'd11) begin fails++; $display("FAIL lbu_after got %h@%0d exp f1@3", obs_wb_data, obs_wb_cycle); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_func3 = 3'b010; bus.req_addr = 64'h4000; bus.req_rd = 5'd8;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_rd_en, bus.wb_valid, bus.err_valid, bus.err_code, bus.wb_rd} !== 11'd0 ||
        (bus.wb_data | bus.mem_addr | bus.err_addr) !== 64'd0) begin
      fails++; $display("FAIL reset_mid got rdy=%b wb=%h ma=%h exp all 0", bus.req_ready, bus.wb_data, bus.mem_addr);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hFFFF;
    repeat (2) begin @(negedge clk); if (bus.wb_valid !== 1'b0 || bus.err_valid !== 1'b0) seen = 1; end
    rst_n = 1'b1; bus.mem_rvalid = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.wb_valid !== 1'b0 || bus.err_valid !== 1'b0) seen = 1; end
    checks++; if (seen) begin fails++; $display("FAIL reset_abort got strobe exp none"); end
    run_load(3'b000, 64'h6001, 5'd2, 64'h0000_0000_0000_7F00, 1);
    checks++; if (!obs_acc || obs_wb_cycle !== 3 || obs_wb_data !== 64'h7F) begin fails++; $display("FAIL after_reset got %h@%0d exp 7f@3", obs_wb_data, obs_wb_cycle); end
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [63:0] a, rdata;
    logic [4:0]  rd;
    int d;
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~(3'((1 << f3[1:0]) - 1));
      rdata = {$urandom, $urandom};
      rd = 5'($urandom);
      d = $urandom_range(1, T + 1);
      model(f3, a, rdata, d);
      run_load(f3, a, rd, rdata, d);
      checks++;
      if (!obs_acc || obs_both || obs_rd_cnt !== exp_rd_cnt) begin
        fails++; $display("FAIL rnd%0d_ctrl acc=%b both=%b rd_cnt=%0d exp rd_cnt=%0d", n, obs_acc, obs_both, obs_rd_cnt, exp_rd_cnt);
      end
      if (exp_rd_cnt == 1) begin
        checks++;
        if (obs_maddr !== {a[63:3], 3'b000}) begin fails++; $display("FAIL rnd%0d_maddr got %h exp %h", n, obs_maddr, {a[63:3], 3'b000}); end
      end
      checks++;
      if (exp_err) begin
        if (obs_err_cycle !== exp_cycle || obs_err_code !== exp_code || obs_err_addr !== a || obs_wb_cycle !== -1) begin
          fails++; $display("FAIL rnd%0d_err got %b@%0d addr %h exp %b@%0d addr %h", n, obs_err_code, obs_err_cycle, obs_err_addr, exp_code, exp_cycle, a);
        end
      end else begin
        if (obs_wb_cycle !== exp_cycle || obs_wb_data !== exp_data || obs_wb_rd !== rd || obs_err_cycle !== -1) begin
          fails++; $display("FAIL rnd%0d_wb f3=%0d got %h@%0d rd %0d exp %h@%0d rd %0d", n, f3, obs_wb_data, obs_wb_cycle, obs_wb_rd, exp_data, exp_cycle, rd);
        end
      end
    end
  endtask

  task automatic test_stats;
    logic [31:0] el, ee;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_load(3'b000, 64'h10, 5'd1, 64'h55, 1);
    run_load(3'b110, 64'h24, 5'd2, 64'h1, 2);
    run_load(3'b001, 64'h31, 5'd3, 64'h1, 1);
    run_load(3'b011, 64'h40, 5'd4, 64'h1, 3);
    run_load(3'b111, 64'h50, 5'd5, 64'h1, 1);
    repeat (2) @(negedge clk);
`ifdef LOAD_SEQ_STATS_EN
    el = 32'd3; ee = 32'd2;
`else
    el = 32'd0; ee = 32'd0;
`endif
    checks++; if (bus.stat_loads !== el) begin fails++; $display("FAIL stat_loads got %0d exp %0d", bus.stat_loads, el); end
    checks++; if (bus.stat_errs !== ee) begin fails++; $display("FAIL stat_errs got %0d exp %0d", bus.stat_errs, ee); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_func3 = 3'd0; bus.req_addr = 64'd0; bus.req_rd = 5'd0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'd0;
    test_reset;
    test_directed;
    test_errors;
    test_timeout;
    test_reset_mid;
    test_random;
    test_stats;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
